// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and the
// TX data register address used by the stream path.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   // TX data register address, mirrors the uart_tx register map.
   localparam logic [4:0] UART_TX_DATA_ADDR = 5'h02;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Stream requester handshake plus the register write port towards uart_tx.
// master: requester/consumer side, slave: the arbiter.
interface uart_tx_arb_if
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*BYTE_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      reg_we;
   logic [4:0]                reg_waddr;
   logic [31:0]               reg_wdata;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ready, reg_we, reg_waddr, reg_wdata
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ready, reg_we, reg_waddr, reg_wdata
   );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first set bit of valid_i starting at
// rr_ptr_i+1 and wrapping modulo NUM_REQ. Returns one-hot and index forms.
module uart_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] pick_oh_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               any_o
);

   // Walk the requesters in priority order and keep the first valid one.
   always_comb begin
      logic        found;
      int unsigned cand;
      pick_oh_o  = '0;
      pick_idx_o = '0;
      found      = 1'b0;
      cand       = 32'd0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = (32'(rr_ptr_i) + off) % NUM_REQ;
         if (!found && valid_i[cand[IDX_W-1:0]]) begin
            pick_oh_o[cand[IDX_W-1:0]] = 1'b1;
            pick_idx_o                 = cand[IDX_W-1:0];
            found                      = 1'b1;
         end else begin
            found = found;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the uart_tx write port between byte-stream
// requesters and the CPU bus. CPU writes take priority; stream beats are
// issued only when the TX FIFO is guaranteed to have room, and a grant is
// held until the end of the packet so packets never interleave.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LVL_W      = 5
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               arb_en_i,
   input  logic               cpu_we_i,
   input  logic [4:0]         cpu_waddr_i,
   input  logic [31:0]        cpu_wdata_i,
   input  logic [LVL_W-1:0]   tx_lvl_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               busy_o,
   uart_tx_arb_if.slave       bus_if
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     gidx_q, gidx_d;
   logic                 reg_we_q, reg_we_d;
   logic [4:0]           reg_waddr_q, reg_waddr_d;
   logic [31:0]          reg_wdata_q, reg_wdata_d;

   logic [NUM_REQ-1:0]   pick_oh;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [LVL_W:0]       lvl_inflight;
   logic                 space;
   logic [NUM_REQ-1:0]   ready;
   logic                 hs;
   logic [BYTE_W-1:0]    gbyte;

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid_i    (bus_if.req_valid),
      .rr_ptr_i   (rr_ptr_q),
      .pick_oh_o  (pick_oh),
      .pick_idx_o (pick_idx),
      .any_o      (pick_any)
   );

   // The write still on reg_we has not reached the level yet, so count it.
   assign lvl_inflight = {1'b0, tx_lvl_i} + {{LVL_W{1'b0}}, reg_we_q};
   assign space        = (lvl_inflight < (LVL_W+1)'(FIFO_DEPTH));
   assign gbyte        = bus_if.req_data[gidx_q*BYTE_W +: BYTE_W];

   // Arbitration FSM: grant selection, ready generation and packet release.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      ready    = '0;
      hs       = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (arb_en_i && pick_any) begin
               state_d = ARB_GRANT;
               grant_d = pick_oh;
               gidx_d  = pick_idx;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            ready[gidx_q] = space && !cpu_we_i;
            hs            = bus_if.req_valid[gidx_q] && ready[gidx_q];
            if (hs && bus_if.req_last[gidx_q]) begin
               state_d  = ARB_IDLE;
               grant_d  = '0;
               rr_ptr_d = gidx_q;
            end else begin
               state_d = ARB_GRANT;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Write port mux: CPU first, then an accepted stream beat, else idle.
   always_comb begin
      reg_we_d    = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      if (cpu_we_i) begin
         reg_we_d    = 1'b1;
         reg_waddr_d = cpu_waddr_i;
         reg_wdata_d = cpu_wdata_i;
      end else if (hs) begin
         reg_we_d    = 1'b1;
         reg_waddr_d = UART_TX_DATA_ADDR;
         reg_wdata_d = {24'h00_0000, gbyte};
      end else begin
         reg_we_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
         grant_q     <= '0;
         gidx_q      <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= 5'h00;
         reg_wdata_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   assign bus_if.req_ready = ready;
   assign bus_if.reg_we    = reg_we_q;
   assign bus_if.reg_waddr = reg_waddr_q;
   assign bus_if.reg_wdata = reg_wdata_q;
   assign grant_o          = grant_q;
   assign busy_o           = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb. A packet-level reference tracks which
// requester owns the port, the round-robin pointer, the expected write on
// the register port and a model of the TX FIFO level that feeds tx_lvl_i.
module tb_uart_tx_arb;
   import uart_pkg::*;

   localparam int NR    = 4;
   localparam int DEPTH = 16;
   localparam int LW    = 5;
   localparam int NCYC  = 3000;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          arb_en_i;
   logic          cpu_we_i;
   logic [4:0]    cpu_waddr_i;
   logic [31:0]   cpu_wdata_i;
   logic [LW-1:0] tx_lvl_i;
   logic [NR-1:0] grant_o;
   logic          busy_o;

   uart_tx_arb_if #(.NUM_REQ(NR)) bus_if ();

   uart_tx_arb #(
      .NUM_REQ    (NR),
      .FIFO_DEPTH (DEPTH),
      .LVL_W      (LW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .arb_en_i    (arb_en_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_waddr_i (cpu_waddr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .tx_lvl_i    (tx_lvl_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o),
      .bus_if      (bus_if.slave)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // First valid requester after rr, wrapping; -1 when nobody is valid.
   function automatic int rr_pick(input logic [NR-1:0] v, input int rr);
      for (int off = 1; off <= NR; off++) begin
         if (v[(rr + off) % NR]) return (rr + off) % NR;
      end
      return -1;
   endfunction

   // Reference state
   int          m_owner;
   int          m_rr;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          cnt;
   int          rem [NR];
   logic [7:0]  cur [NR];

   logic [NR-1:0] vv;
   logic [NR-1:0] exp_ready;
   logic [NR-1:0] exp_grant;
   logic [NR*8-1:0] dd;
   logic [NR-1:0] ll;
   logic          rst_now, en_now, cpu_now, hs, rd, wr, space, rst_done;
   int            vprob, rprob, maxlen, old;

   initial begin
      reset_i  = 1'b1;
      arb_en_i = 1'b0;
      cpu_we_i = 1'b0;
      cpu_waddr_i = 5'h00;
      cpu_wdata_i = 32'h0;
      tx_lvl_i = '0;
      bus_if.req_valid = '0;
      bus_if.req_data  = '0;
      bus_if.req_last  = '0;
      m_owner = -1; m_rr = NR - 1; m_we = 1'b0; m_addr = 5'h00; m_data = 32'h0;
      cnt = 0;
      rst_done = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 1;
         cur[i] = 8'($urandom);
      end
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         // Registered outputs after the last edge
         exp_grant = '0;
         if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
         chk_eq("grant", 32'(grant_o), 32'(exp_grant));
         chk_eq("busy", 32'(busy_o), 32'(m_owner >= 0));
         chk_eq("reg_we", 32'(bus_if.reg_we), 32'(m_we));
         chk_eq("reg_waddr", 32'(bus_if.reg_waddr), 32'(m_addr));
         chk_eq("reg_wdata", bus_if.reg_wdata, m_data);

         // Phase shaping: single-byte packets first, then mixed lengths,
         // alternating FIFO drain rates, periodic arbitration disable.
         maxlen  = (cyc < 400) ? 1 : 4;
         vprob   = (cyc < 400) ? 100 : 80;
         rprob   = (((cyc / 500) % 2) == 1) ? 20 : 70;
         en_now  = ((cyc % 300) < 250);
         rst_now = (cyc >= 1500) && !rst_done && (m_owner >= 0) && (rem[m_owner] > 1);
         if (rst_now) rst_done = 1'b1;
         cpu_now = ($urandom_range(0, 99) < 8);

         reset_i     = rst_now;
         arb_en_i    = en_now;
         cpu_we_i    = cpu_now;
         cpu_waddr_i = ($urandom_range(0, 1) == 0) ? UART_TX_DATA_ADDR : 5'($urandom);
         cpu_wdata_i = $urandom;
         tx_lvl_i    = LW'(cnt);
         for (int i = 0; i < NR; i++) begin
            vv[i]        = ($urandom_range(0, 99) < vprob);
            dd[i*8 +: 8] = cur[i];
            ll[i]        = (rem[i] == 1);
         end
         bus_if.req_valid = vv;
         bus_if.req_data  = dd;
         bus_if.req_last  = ll;
         #1;

         // Ready: owner only, FIFO room including the write in flight, no CPU
         space     = ((cnt + int'(m_we)) < DEPTH);
         exp_ready = '0;
         if (m_owner >= 0 && space && !cpu_now) exp_ready[m_owner] = 1'b1;
         chk_eq("ready", 32'(bus_if.req_ready), 32'(exp_ready));

         // FIFO level seen next cycle: write landing now, random engine read
         wr  = m_we && (m_addr == UART_TX_DATA_ADDR);
         old = cnt;
         rd  = (old > 0) && ($urandom_range(0, 99) < rprob);
         cnt = old + int'(wr) - int'(rd);
         if (cnt > DEPTH) cnt = DEPTH;

         if (rst_now) begin
            m_owner = -1; m_rr = NR - 1; m_we = 1'b0; m_addr = 5'h00; m_data = 32'h0;
         end else begin
            hs = (m_owner >= 0) && vv[m_owner] && exp_ready[m_owner];
            if (cpu_now) begin
               m_we = 1'b1; m_addr = cpu_waddr_i; m_data = cpu_wdata_i;
            end else if (hs) begin
               m_we = 1'b1; m_addr = UART_TX_DATA_ADDR; m_data = {24'h0, cur[m_owner]};
            end else begin
               m_we = 1'b0;
            end
            if (m_owner < 0) begin
               if (en_now) m_owner = rr_pick(vv, m_rr);
            end else if (hs) begin
               int o;
               o = m_owner;
               if (rem[o] == 1) begin
                  m_rr    = o;
                  m_owner = -1;
               end
               rem[o] = rem[o] - 1;
               cur[o] = 8'($urandom);
               if (rem[o] == 0) rem[o] = $urandom_range(1, maxlen);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
